// File: rtl/dmem_store_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_store_buffer_if
// Purpose  : Core store/load port and RAM write/read port of the store buffer.
// Revision : 1.0  initial release
// ============================================================================
interface dmem_store_buffer_if #(
    parameter int CNT_W = 3
);
    logic             st_valid;
    logic             st_byte;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic             st_ready;
    logic [31:0]      ld_addr;
    logic [31:0]      ld_data;
    logic [29:0]      mem_raddr;
    logic [31:0]      mem_rdata;
    logic             mem_wvalid;
    logic             mem_wready;
    logic [29:0]      mem_waddr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_wbe;
    logic [CNT_W-1:0] count;
    logic             empty;

    modport slave (
        input  st_valid, st_byte, st_addr, st_data, ld_addr, mem_rdata, mem_wready,
        output st_ready, ld_data, mem_raddr, mem_wvalid, mem_waddr, mem_wdata, mem_wbe,
               count, empty
    );

    modport master (
        output st_valid, st_byte, st_addr, st_data, ld_addr, mem_rdata, mem_wready,
        input  st_ready, ld_data, mem_raddr, mem_wvalid, mem_waddr, mem_wdata, mem_wbe,
               count, empty
    );
endinterface
`default_nettype wire

// File: rtl/dmem_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : dmem_store_buffer
// Purpose  : Posted-write FIFO between core data port and word RAM, with
//            byte-wise load forwarding from pending stores.
// Revision : 1.0  initial release
// ============================================================================
module dmem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  wire logic          clk,
    input  wire logic          reset,
    dmem_store_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [29:0]      addr_q [DEPTH];
    logic [29:0]      addr_d [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [3:0]       be_q   [DEPTH];
    logic [3:0]       be_d   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             st_ready;
    logic             wvalid;
    logic             enq;
    logic             deq;
    logic [3:0]       st_be;
    logic [31:0]      st_wdata;
    logic [PTR_W-1:0] fwd_idx;
    logic [31:0]      ld_word;
    logic             unused_ld_lsb;

    // No pass-through when full: a same-cycle dequeue never opens a slot.
    assign st_ready = (count_q < CNT_W'(DEPTH));
    assign wvalid   = (count_q != '0);
    assign enq      = bus.st_valid & st_ready;
    assign deq      = wvalid & bus.mem_wready;

    always_comb begin
        st_be    = bus.st_byte ? (4'b0001 << bus.st_addr[1:0]) : 4'b1111;
        st_wdata = bus.st_byte ? {4{bus.st_data[7:0]}} : bus.st_data;
    end

    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        be_d     = be_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            addr_d[wr_ptr_q] = bus.st_addr[31:2];
            data_d[wr_ptr_q] = st_wdata;
            be_d[wr_ptr_q]   = st_be;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Entry storage is cleared too so the head outputs read zero out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            be_q     <= be_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Walk oldest to youngest so the youngest matching lane wins.
    always_comb begin
        ld_word = bus.mem_rdata;
        fwd_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addr_q[fwd_idx] == bus.ld_addr[31:2])) begin
                for (int k = 0; k < 4; k++) begin
                    if (be_q[fwd_idx][k]) begin
                        ld_word[8*k +: 8] = data_q[fwd_idx][8*k +: 8];
                    end
                end
            end
        end
    end

    assign unused_ld_lsb  = ^bus.ld_addr[1:0];

    assign bus.st_ready   = st_ready;
    assign bus.empty      = ~wvalid;
    assign bus.count      = count_q;
    assign bus.mem_wvalid = wvalid;
    assign bus.mem_waddr  = addr_q[rd_ptr_q];
    assign bus.mem_wdata  = data_q[rd_ptr_q];
    assign bus.mem_wbe    = be_q[rd_ptr_q];
    assign bus.mem_raddr  = bus.ld_addr[31:2];
    assign bus.ld_data    = ld_word;

endmodule
`default_nettype wire

// File: tb/tb_dmem_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_store_buffer
// Purpose  : Directed bench for dmem_store_buffer with a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_store_buffer;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    logic clk;
    logic reset;
    logic chk_en;
    int   vectors;
    int   miscompares;

    ent_t mq[$];
    ent_t wlog[$];
    ent_t exp_log[$];

    dmem_store_buffer_if #(.CNT_W(CNT_W)) bus ();

    dmem_store_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ent_t mk_entry(input logic b, input logic [31:0] a, input logic [31:0] d);
        ent_t e;
        e.addr = a[31:2];
        if (b) begin
            e.be   = 4'b0001 << a[1:0];
            e.data = {4{d[7:0]}};
        end else begin
            e.be   = 4'b1111;
            e.data = d;
        end
        return e;
    endfunction

    function automatic logic [31:0] model_ld();
        logic [31:0] r;
        r = bus.mem_rdata;
        foreach (mq[i]) begin
            if (mq[i].addr == bus.ld_addr[31:2]) begin
                for (int k = 0; k < 4; k++) begin
                    if (mq[i].be[k]) r[8*k +: 8] = mq[i].data[8*k +: 8];
                end
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a plain queue of pending writes, updated on the same edges as the DUT.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
        end else begin
            logic m_enq, m_deq;
            ent_t e;
            m_enq = bus.st_valid && (mq.size() < DEPTH);
            m_deq = bus.mem_wready && (mq.size() > 0);
            e     = mk_entry(bus.st_byte, bus.st_addr, bus.st_data);
            if (m_deq) void'(mq.pop_front());
            if (m_enq) mq.push_back(e);
        end
    end

    always @(posedge clk) begin
        if (reset && bus.mem_wvalid && bus.mem_wready) begin
            ent_t w;
            w.addr = bus.mem_waddr;
            w.data = bus.mem_wdata;
            w.be   = bus.mem_wbe;
            wlog.push_back(w);
        end
    end

    always @(negedge clk) begin
        if (reset && chk_en) begin
            check("count",     32'(bus.count), 32'(mq.size()));
            check("empty",     32'(bus.empty), 32'(mq.size() == 0));
            check("st_ready",  32'(bus.st_ready), 32'(mq.size() < DEPTH));
            check("wvalid",    32'(bus.mem_wvalid), 32'(mq.size() > 0));
            check("mem_raddr", 32'(bus.mem_raddr), 32'(bus.ld_addr[31:2]));
            check("ld_data",   bus.ld_data, model_ld());
            if (mq.size() > 0) begin
                check("head_addr", 32'(bus.mem_waddr), 32'(mq[0].addr));
                check("head_data", bus.mem_wdata, mq[0].data);
                check("head_be",   32'(bus.mem_wbe), 32'(mq[0].be));
            end
        end
    end

    task automatic drive(input logic v, input logic b, input logic [31:0] a,
                         input logic [31:0] d, input logic wr);
        bus.st_valid   = v;
        bus.st_byte    = b;
        bus.st_addr    = a;
        bus.st_data    = d;
        bus.mem_wready = wr;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] rd);
        bus.ld_addr   = a;
        bus.mem_rdata = rd;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic store(input logic b, input logic [31:0] a, input logic [31:0] d, input logic wr);
        drive(1'b1, b, a, d, wr);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic v;
        logic bsel;
        logic [31:0] a;
        vectors     = 0;
        miscompares = 0;
        chk_en      = 1'b0;
        reset       = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        load(32'h0, 32'h0);

        // Reset values
        #12;
        check("rst_wvalid",   32'(bus.mem_wvalid), 32'h0);
        check("rst_wbe",      32'(bus.mem_wbe), 32'h0);
        check("rst_waddr",    32'(bus.mem_waddr), 32'h0);
        check("rst_wdata",    bus.mem_wdata, 32'h0);
        check("rst_st_ready", 32'(bus.st_ready), 32'h1);
        check("rst_empty",    32'(bus.empty), 32'h1);
        check("rst_count",    32'(bus.count), 32'h0);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        chk_en = 1'b1;

        // Word store, written the cycle after it is accepted
        store(1'b0, 32'h64, 32'hDEADBEEF, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        mid();
        check("t2_wvalid", 32'(bus.mem_wvalid), 32'h1);
        check("t2_waddr",  32'(bus.mem_waddr), 32'h19);
        check("t2_wbe",    32'(bus.mem_wbe), 32'hF);
        check("t2_wdata",  bus.mem_wdata, 32'hDEADBEEF);
        cyc();
        mid();
        check("t2_count0", 32'(bus.count), 32'h0);
        cyc();

        // Fill while RAM stalls, then a store presented while full is dropped
        for (int i = 0; i < 4; i++) store(1'b0, 32'h100 + 32'(4 * i), 32'(i + 1), 1'b0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        mid();
        check("t3_count4",   32'(bus.count), 32'h4);
        check("t3_st_ready", 32'(bus.st_ready), 32'h0);
        check("t3_head",     bus.mem_wdata, 32'h1);
        cyc();
        drive(1'b1, 1'b0, 32'h200, 32'h99, 1'b1);
        mid();
        check("t3_full_rdy", 32'(bus.st_ready), 32'h0);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        mid();
        check("t3_count3",   32'(bus.count), 32'h3);
        check("t3_head2",    32'(bus.mem_waddr), 32'h41);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        repeat (3) cyc();

        // Byte store lane replication, then simultaneous enqueue/dequeue
        store(1'b1, 32'h66, 32'h000000AB, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        mid();
        check("t4_wbe",   32'(bus.mem_wbe), 32'h4);
        check("t4_wdata", bus.mem_wdata, 32'hABABABAB);
        check("t4_waddr", 32'(bus.mem_waddr), 32'h19);
        cyc();
        drive(1'b1, 1'b0, 32'h70, 32'h12345678, 1'b1);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        mid();
        check("t4_cnt_same", 32'(bus.count), 32'h1);
        check("t4_new_head", bus.mem_wdata, 32'h12345678);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        cyc();

        // Forwarding merge of word and byte stores
        store(1'b0, 32'h60, 32'h11223344, 1'b0);
        drive(1'b1, 1'b1, 32'h61, 32'h000000AA, 1'b0);
        load(32'h60, 32'h0);
        mid();
        check("t5_not_yet", bus.ld_data, 32'h11223344);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        mid();
        check("t5_merge", bus.ld_data, 32'h1122AA44);
        check("t5_raddr", 32'(bus.mem_raddr), 32'h18);
        load(32'h62, 32'hFFFFFFFF);
        #1;
        check("t5_merge_ff", bus.ld_data, 32'h1122AA44);
        load(32'h64, 32'h55667788);
        #1;
        check("t5_miss", bus.ld_data, 32'h55667788);
        cyc();
        load(32'h0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        repeat (2) cyc();

        // Asynchronous reset in the middle of a cycle with stores queued
        store(1'b0, 32'h80, 32'h1, 1'b0);
        store(1'b0, 32'h84, 32'h2, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("t1_wvalid",   32'(bus.mem_wvalid), 32'h0);
        check("t1_count",    32'(bus.count), 32'h0);
        check("t1_st_ready", 32'(bus.st_ready), 32'h1);
        check("t1_empty",    32'(bus.empty), 32'h1);
        check("t1_wbe",      32'(bus.mem_wbe), 32'h0);
        check("t1_waddr",    32'(bus.mem_waddr), 32'h0);
        check("t1_wdata",    bus.mem_wdata, 32'h0);
        cyc();
        reset = 1'b1;
        cyc();

        // Fill, then drain with toggling wready and refills that wrap the pointers
        wlog.delete();
        exp_log.delete();
        for (int i = 0; i < 4; i++) begin
            store(1'b0, 32'h300 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0);
            exp_log.push_back(mk_entry(1'b0, 32'h300 + 32'(4 * i), 32'hA0 + 32'(i)));
        end
        for (int j = 0; j < 12; j++) begin
            v    = (mq.size() < DEPTH);
            bsel = (j % 4 == 1);
            a    = 32'h400 + 32'(4 * j) + (bsel ? 32'h3 : 32'h0);
            drive(v, bsel, a, 32'hB0 + 32'(j), (j % 2 == 0));
            if (v) exp_log.push_back(mk_entry(bsel, a, 32'hB0 + 32'(j)));
            cyc();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (mq.size() == 0) break;
            cyc();
        end
        mid();
        check("t6_empty", 32'(bus.empty), 32'h1);
        check("t6_len",   32'(wlog.size()), 32'(exp_log.size()));
        if (wlog.size() > 0) begin
            check("t6_first_addr", 32'(wlog[0].addr), 32'hC0);
            check("t6_first_data", wlog[0].data, 32'hA0);
        end else begin
            check("t6_first_present", 32'h0, 32'h1);
        end
        for (int i = 0; i < exp_log.size() && i < wlog.size(); i++) begin
            check("t6_log_addr", 32'(wlog[i].addr), 32'(exp_log[i].addr));
            check("t6_log_data", wlog[i].data, exp_log[i].data);
            check("t6_log_be",   32'(wlog[i].be), 32'(exp_log[i].be));
        end
        cyc();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
